accumulator_requant_unit: RTL
=============================

Name: accumulator_requant_unit

Overview:
- Sits directly downstream of the 16x16 matrix multiply unit and consumes its 16-lane, 20-bit signed column sums.
- Accumulates successive K-tile partial sums into a small register-file of 32-bit accumulators, one row per output vector.
- On command, drains a range of rows, requantizing each lane to signed int8 by rounding arithmetic right shift plus clip.
- The drained 128-bit result is in the same lane packing as the multiply unit's activation input, so it can feed the next layer.

Parameters:
LANES, 16, number of lanes (columns)
IN_W, 20, signed input width per lane
ACC_W, 32, signed accumulator width per lane
DEPTH, 16, accumulator rows
AW, 4, row address width (log2 DEPTH)

Ports:
clk  input  1  clock
reset_n  input  1  reset, asynchronous, active-low
in_valid  input  1  partial-sum vector valid
in_ready  output  1  unit can accept a partial-sum write
in_data  input  LANES*IN_W (320)  lane j at bits [(j+1)*20-1 : j*20], signed
in_addr  input  AW  target accumulator row
in_acc  input  1  1 = accumulate into row, 0 = overwrite row
drain_start  input  1  start drain (sampled only in IDLE)
drain_base  input  AW  first row to drain
drain_len  input  AW+1  rows to drain, 1..DEPTH; 0 = ignored
shift  input  5  requant right-shift amount, latched at drain_start
out_valid  output  1  requantized row valid
out_ready  input  1  downstream accepts the row
out_data  output  LANES*8 (128)  lane j at bits [(j+1)*8-1 : j*8], signed int8
out_addr  output  AW  row index of out_data
busy  output  1  high in DRAIN
ovf_flag  output  1  sticky saturation/clip indicator

Behaviour:
- Reset (asynchronous, active-low):
  - All accumulators = 0.
  - FSM = IDLE; latched shift = 0.
  - out_valid = 0, out_data = 0, out_addr = 0, busy = 0, ovf_flag = 0.
  - in_ready = 1 once reset is released.
  - A reset during DRAIN aborts the drain immediately and discards any pending output.
- FSM states:
  - IDLE: in_ready = 1.
    - A write occurs on an edge where in_valid && in_ready.
    - drain_start with drain_len != 0 moves to DRAIN; drain_len = 0 keeps IDLE.
  - DRAIN: in_ready = 0, busy = 1.
    - Returns to IDLE on the edge of the final out_valid && out_ready handshake.
- Write arithmetic, per lane:
  - Sign-extend in_data to ACC_W.
  - in_acc = 1: new = sat_ACC_W(acc + sext(in)); in_acc = 0: new = sext(in).
  - The result is registered at the edge and visible to the next cycle's write or drain.
  - Back-to-back writes to the same row must accumulate correctly, with no hazard bubble.
  - Saturation clamps to [-2^31, 2^31-1] and sets ovf_flag.
- Same-cycle write and drain in IDLE:
  - The write is committed and the drain starts at the same edge.
  - The first drained row includes that write.
- Drain:
  - Row pointer starts at drain_base and increments modulo DEPTH (wrap from row 15 to row 0); remaining count starts at drain_len.
  - The first out_valid rises 1 cycle after the drain_start edge.
  - The output register loads a row, then holds out_valid, out_data and out_addr stable until out_ready.
  - On handshake, the next row loads at the same edge, giving 1 row/cycle throughput when out_ready is held high.
  - out_valid falls after the last handshake.
  - Each drained row is cleared to 0 on its handshake edge (clear-on-read).
- Requant, per lane, with s = latched shift:
  - r = (acc + (s ? 2^(s-1) : 0)) >>> s, computed in ACC_W+1 bits so it cannot overflow.
  - out = clip(r, -128, 127).
  - Any clip sets ovf_flag.
- ovf_flag:
  - Cleared on an accepted drain_start edge.
  - A set condition on the same edge wins over the clear.
- drain_start in DRAIN: ignored. in_valid in DRAIN: not accepted; the sender holds.

Test Plan:
- Reset then write row 3, in_acc = 0, all lanes = 100; write row 3, in_acc = 1, all lanes = -30; drain base 3, len 1, shift 0, out_ready = 1 -> out_valid 1 cycle after start, out_data all lanes 70, out_addr 3, ovf_flag 0, row 3 then reads 0.
- Row 0 lane 5 = 11, shift 2 -> (11+2)>>>2 = 3; lane 6 = -11 -> (-11+2)>>>2 = -3; lane 7 = 1000, shift 0 -> clips to 127 and ovf_flag = 1.
- Drain base 14, len 4, out_ready toggling 1,0,0,1,1,0,1 -> out_addr sequence 14, 15, 0, 1; out_data held stable during stalls; busy falls after the 4th handshake; in_ready = 0 throughout the drain.
- Accumulate 2^31-1 into row 2 lane 0 via repeated writes of 2^19-1 -> saturates at 2147483647, ovf_flag = 1; the next drain_start clears the flag.
- Same-cycle in_valid (row 1, overwrite, lanes = 5) and drain_start (base 1, len 1) -> drained lanes = 5.
- Assert reset_n low mid-drain with out_valid = 1 -> out_valid = 0 and busy = 0 immediately; all rows read 0 after release; drain_len = 0 start leaves busy = 0.

Source files
------------

// File: rtl/accumulator_requant_unit_if.sv
// accumulator_requant_unit_if: partial-sum write, drain command and requantized-row output signals.
interface accumulator_requant_unit_if #(
    parameter int LANES = 16,
    parameter int IN_W  = 20,
    parameter int AW    = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_data;
    logic [AW-1:0]         in_addr;
    logic                  in_acc;
    logic                  drain_start;
    logic [AW-1:0]         drain_base;
    logic [AW:0]           drain_len;
    logic [4:0]            shift;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*8-1:0]    out_data;
    logic [AW-1:0]         out_addr;
    logic                  busy;
    logic                  ovf_flag;

    modport master (
        output in_valid, in_data, in_addr, in_acc, drain_start, drain_base, drain_len, shift, out_ready,
        input  in_ready, out_valid, out_data, out_addr, busy, ovf_flag
    );

    modport slave (
        input  in_valid, in_data, in_addr, in_acc, drain_start, drain_base, drain_len, shift, out_ready,
        output in_ready, out_valid, out_data, out_addr, busy, ovf_flag
    );
endinterface

// File: rtl/accumulator_requant_unit.sv
// accumulator_requant_unit: saturating K-tile accumulation into a row file, drained as
// round-shift-clipped int8 rows with clear-on-read.
module accumulator_requant_unit #(
    parameter int LANES = 16,
    parameter int IN_W  = 20,
    parameter int ACC_W = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic                          clk,
    input logic                          reset_n,
    accumulator_requant_unit_if.slave    bus
);
    typedef enum logic {IDLE, DRAIN} state_t;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] Q_MAX = 127;
    localparam logic signed [ACC_W:0] Q_MIN = -128;

    state_t                       state_q;
    logic [LANES-1:0][ACC_W-1:0]  acc_q [DEPTH];
    logic [LANES-1:0][ACC_W-1:0]  wr_row_d;
    logic [LANES*8-1:0]           out_data_q, out_data_d;
    logic [AW-1:0]                out_addr_q, ptr_q;
    logic [AW:0]                  rem_q;
    logic [4:0]                   shift_q;
    logic                         out_valid_q, ovf_q;
    logic                         wr_en, start, hs, ld, wr_sat, rq_clip;
    logic signed [ACC_W:0]        wsum, rsum, rnd;

    // One extra bit of headroom makes both the saturating add and the rounding add overflow-free.
    always_comb begin
        wr_en      = bus.in_valid && state_q == IDLE;
        start      = bus.drain_start && state_q == IDLE && bus.drain_len != '0;
        hs         = out_valid_q && bus.out_ready;
        ld         = state_q == DRAIN && rem_q != '0 && (!out_valid_q || bus.out_ready);
        rnd        = shift_q == '0 ? '0 : (ACC_W+1)'(1) << (shift_q - 5'd1);
        wr_sat     = 1'b0;
        rq_clip    = 1'b0;
        wsum       = '0;
        rsum       = '0;
        wr_row_d   = '0;
        out_data_d = '0;
        for (int j = 0; j < LANES; j++) begin
            wsum = (ACC_W+1)'(signed'(bus.in_data[j*IN_W +: IN_W]));
            if (bus.in_acc) wsum = wsum + (ACC_W+1)'(signed'(acc_q[bus.in_addr][j]));
            wr_row_d[j] = wsum[ACC_W] != wsum[ACC_W-1] ? (wsum[ACC_W] ? ACC_MIN : ACC_MAX) : wsum[ACC_W-1:0];
            wr_sat      = wr_sat | (wsum[ACC_W] != wsum[ACC_W-1]);
            rsum = ((ACC_W+1)'(signed'(acc_q[ptr_q][j])) + rnd) >>> shift_q;
            out_data_d[j*8 +: 8] = rsum > Q_MAX ? 8'h7f : rsum < Q_MIN ? 8'h80 : rsum[7:0];
            rq_clip     = rq_clip | rsum > Q_MAX | rsum < Q_MIN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            for (int r = 0; r < DEPTH; r++) acc_q[r] <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (wr_en) acc_q[bus.in_addr] <= wr_row_d;
            if (hs) acc_q[out_addr_q] <= '0;
            if (ld) begin
                out_data_q <= out_data_d;
                out_addr_q <= ptr_q;
                ptr_q      <= ptr_q + 1'b1;
                rem_q      <= rem_q - 1'b1;
            end
            out_valid_q <= ld || (out_valid_q && !bus.out_ready);
            ovf_q       <= (wr_en && wr_sat) || (ld && rq_clip) || (ovf_q && !start);
            case (state_q)
                IDLE: if (start) begin
                    state_q <= DRAIN;
                    shift_q <= bus.shift;
                    ptr_q   <= bus.drain_base;
                    rem_q   <= bus.drain_len;
                end
                DRAIN: if (hs && rem_q == '0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q == DRAIN;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.ovf_flag  = ovf_q;
endmodule
